vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- VGA source side: generates 640x480@60 Hz sync timing (negative-polarity hs/vs) and fetches pixels from an upstream pixel source (framebuffer or pattern generator) through a fixed-latency request interface.
- Drives registered 4-bit red/green/blue, hs and vs into the board VGA DAC pins and into the frame-capture bench monitor.
- Produces the same signal set that the capture monitor consumes.

Parameters:
- H_SYNC, 96, hs low width in clocks
- H_BP, 48, horizontal back porch clocks
- H_ACT, 640, active pixels per line
- H_FP, 16, horizontal front porch clocks
- V_SYNC, 2, vs low width in lines
- V_BP, 33, vertical back porch lines
- V_ACT, 480, active lines per frame
- V_FP, 10, vertical front porch lines
- RD_LAT, 1, pixel source read latency in clocks, legal range 0..4

Ports:
- clk_vga  in  1  pixel clock (25 MHz nominal)
- rst  in  1  asynchronous reset, active-high
- en  in  1  timing enable; low holds the generator idle
- pix_req  out  1  pixel fetch strobe, high for every active pixel position
- pix_x  out  10  active column 0..H_ACT-1 for the current request, 0 when pix_req low
- pix_y  out  10  active row 0..V_ACT-1 for the current request, 0 when pix_req low
- pix_data  in  12  {r[3:0],g[3:0],b[3:0]}, valid exactly RD_LAT clocks after pix_req
- red  out  4  pixel red, 0 outside active region
- green  out  4  pixel green, 0 outside active region
- blue  out  4  pixel blue, 0 outside active region
- hs  out  1  horizontal sync, active low
- vs  out  1  vertical sync, active low
- de  out  1  data enable, high on active pixels
- frame_start  out  1  one-clock pulse coincident with the first de of each frame (x=0, y=0)

Behaviour:
- Totals: H_TOTAL = H_SYNC+H_BP+H_ACT+H_FP (800); V_TOTAL = sum of the V parameters (525). Both must be ≤ 1024; counters are 10-bit unsigned.
- Stage 0 counters:
  - h_cnt runs 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments when h_cnt wraps, runs 0..V_TOTAL-1 and wraps to 0.
  - Line order: sync, back porch, active, front porch. Frame order is the same, in lines.
- Stage 0 decode:
  - hs_i = (h_cnt < H_SYNC) ? 0 : 1
  - vs_i = (v_cnt < V_SYNC) ? 0 : 1
  - act = h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACT) and v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACT)
- pix_req, pix_x and pix_y are combinational from the stage 0 registers:
  - pix_req = act & en
  - pix_x = h_cnt - (H_SYNC+H_BP)
  - pix_y = v_cnt - (V_SYNC+V_BP)
- Pipeline: hs_i, vs_i, act and a first-pixel flag pass through an RD_LAT-deep delay line plus one output register. Total latency from stage 0 to the pins is L = RD_LAT+1 clocks.
- Output register at each clock:
  - hs and vs take the delayed decode values.
  - de takes the delayed act.
  - {red,green,blue} = delayed act ? pix_data : 0
  - frame_start = delayed act & delayed first-pixel flag, where the first-pixel flag = pix_x==0 & pix_y==0.
- vs transitions coincide with an hs falling edge (v_cnt only changes at h_cnt=0).
- en low:
  - Next clock, h_cnt and v_cnt load 0 and stay at 0.
  - pix_req is held 0.
  - The values entering the pipeline are forced to hs_i=1, vs_i=1, act=0, so after L clocks the outputs sit at hs=1, vs=1, de=0, rgb=0.
- en rising: counting resumes from h_cnt=0, v_cnt=0, i.e. a full new frame starting with sync. There are no partial frames after enable.
- Reset, at any time including mid-line or mid-frame, acts asynchronously:
  - h_cnt=0, v_cnt=0.
  - All pipeline stages and outputs: hs=1, vs=1, de=0, red=green=blue=0, frame_start=0.
  - After rst deasserts with en high, the first hs falling edge appears at the pins L clocks later.
- pix_data is ignored whenever the delayed act is 0. Nonzero data during blanking must not reach the pins.
- No backpressure: the pixel source must honour RD_LAT exactly.

Decomposition:
- Package vga_timing_pkg holds:
  - default timing constants (640x480@60 values)
  - the packed 12-bit rgb444 pixel typedef
  - the sync polarity constant SYNC_ACTIVE = 0
- One sub-module, vga_delay_line: a parameterized-width, parameterized-depth (0..4) shift register with async active-high reset to a parameterized reset value. It is used for the control pipeline. Depth 0 is a pass-through.

Test Plan:
- Reset: assert rst mid-line -> same clock hs=1, vs=1, de=0, rgb=0, frame_start=0. Release with en=1 and RD_LAT=1 -> hs falls 2 clocks later, stays low 96 clocks, period 800 clocks.
- Frame timing (default params): vs low for exactly 1600 clocks; vs period 420000 clocks; de high 640 consecutive clocks per line on 480 lines; 307200 de cycles per frame.
- Data alignment, RD_LAT=2: source returns pix_data={pix_x[3:0],pix_y[3:0],4'hA} delayed 2 clocks -> at every de cycle rgb equals that function of the monitor-counted (x,y); first pixel of frame rgb=12'h00A with frame_start=1.
- Blanking: source drives constant 12'hFFF -> rgb=0 whenever de=0; rgb=12'hFFF whenever de=1.
- Enable toggle: drop en at line 200 column 300, hold 1000 clocks, raise -> outputs idle (hs=vs=1, de=0) L clocks after the drop; next activity is a fresh frame, vs falling with hs falling L clocks after en rises.
- Small config: H=4/2/8/2, V=1/1/4/1, RD_LAT=0 -> line 16 clocks, frame 112 clocks, pix_x wraps 7->0, v_cnt wraps 6->0; the monitor captures a 8x4 frame.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared timing defaults, sync polarity and the packed pixel type for the VGA source.
package vga_timing_pkg;

    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;
    localparam int DEF_H_ACT  = 640;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;
    localparam int DEF_V_ACT  = 480;
    localparam int DEF_V_FP   = 10;
    localparam int DEF_RD_LAT = 1;

    localparam logic SYNC_ACTIVE = 1'b0;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with async reset to RST_VAL; depth 0 degenerates to a wire.
module vga_delay_line #(
    parameter int                WIDTH   = 1,
    parameter int                DEPTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = ^{clk, rst};
            assign q = d;
        end else begin : g_shift
            logic [WIDTH-1:0] sr_q [DEPTH];
            logic [WIDTH-1:0] sr_d [DEPTH];

            always_comb begin
                sr_d[0] = d;
                for (int i = 1; i < DEPTH; i++) begin
                    sr_d[i] = sr_q[i-1];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        sr_q[i] <= RST_VAL;
                    end
                end else begin
                    sr_q <= sr_d;
                end
            end

            assign q = sr_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA sync/timing generator: stage-0 counters, fixed-latency pixel fetch, and a
// control pipeline that realigns sync/de with returning pixel data at the pins.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP   = DEF_H_BP,
    parameter int H_ACT  = DEF_H_ACT,
    parameter int H_FP   = DEF_H_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP   = DEF_V_BP,
    parameter int V_ACT  = DEF_V_ACT,
    parameter int V_FP   = DEF_V_FP,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic        clk_vga,
    input  logic        rst,
    input  logic        en,
    output logic        pix_req,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    input  logic [11:0] pix_data,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        hs,
    output logic        vs,
    output logic        de,
    output logic        frame_start
);

    // Bounds are 11 bits so a 1024-clock total still compares cleanly.
    localparam logic [10:0] H_SYNC_END = 11'(H_SYNC);
    localparam logic [10:0] H_ACT_BEG  = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_ACT_END  = 11'(H_SYNC + H_BP + H_ACT);
    localparam logic [10:0] V_SYNC_END = 11'(V_SYNC);
    localparam logic [10:0] V_ACT_BEG  = 11'(V_SYNC + V_BP);
    localparam logic [10:0] V_ACT_END  = 11'(V_SYNC + V_BP + V_ACT);
    localparam logic [9:0]  H_ORG      = 10'(H_SYNC + H_BP);
    localparam logic [9:0]  V_ORG      = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  H_LAST     = 10'(H_SYNC + H_BP + H_ACT + H_FP - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_SYNC + V_BP + V_ACT + V_FP - 1);
    localparam logic [3:0]  CTRL_IDLE  = {~SYNC_ACTIVE, ~SYNC_ACTIVE, 2'b00};

    logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [10:0] h_ext, v_ext;
    logic [9:0]  x_raw, y_raw;
    logic        act;
    logic [3:0]  ctrl_in, ctrl_dl;          // {hs, vs, act, first_pixel}

    logic    hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
    rgb444_t rgb_q, rgb_d;

    assign h_ext = {1'b0, h_cnt_q};
    assign v_ext = {1'b0, v_cnt_q};

    always_comb begin
        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (!en) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
        end
    end

    always_comb begin
        x_raw   = h_cnt_q - H_ORG;
        y_raw   = v_cnt_q - V_ORG;
        act     = (h_ext >= H_ACT_BEG) && (h_ext < H_ACT_END) &&
                  (v_ext >= V_ACT_BEG) && (v_ext < V_ACT_END);
        pix_req = act & en;
        pix_x   = pix_req ? x_raw : 10'd0;
        pix_y   = pix_req ? y_raw : 10'd0;
        ctrl_in = CTRL_IDLE;
        if (en) begin
            ctrl_in = {(h_ext < H_SYNC_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE,
                       (v_ext < V_SYNC_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE,
                       act,
                       (x_raw == 10'd0) && (y_raw == 10'd0)};
        end
    end

    // Control rides alongside the pixel fetch so it meets pix_data at the output register.
    vga_delay_line #(
        .WIDTH   (4),
        .DEPTH   (RD_LAT),
        .RST_VAL (CTRL_IDLE)
    ) u_ctrl_dly (
        .clk (clk_vga),
        .rst (rst),
        .d   (ctrl_in),
        .q   (ctrl_dl)
    );

    always_comb begin
        hs_d  = ctrl_dl[3];
        vs_d  = ctrl_dl[2];
        de_d  = ctrl_dl[1];
        rgb_d = ctrl_dl[1] ? rgb444_t'(pix_data) : rgb444_t'(12'h000);
        fs_d  = ctrl_dl[1] & ctrl_dl[0];
    end

    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            hs_q    <= ~SYNC_ACTIVE;
            vs_q    <= ~SYNC_ACTIVE;
            de_q    <= 1'b0;
            rgb_q   <= '0;
            fs_q    <= 1'b0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            rgb_q   <= rgb_d;
            fs_q    <= fs_d;
        end
    end

    assign hs          = hs_q;
    assign vs          = vs_q;
    assign de          = de_q;
    assign red         = rgb_q.r;
    assign green       = rgb_q.g;
    assign blue        = rgb_q.b;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full 640x480 line/sync timing on one instance, plus 8x4 small
// frames at read latency 0 and 2 for data alignment, blanking and enable toggling.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst;
    logic en_a, en_b, en_c;
    logic sel_c;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    function automatic logic [11:0] pat(input logic [9:0] x, input logic [9:0] y);
        return {x[3:0], y[3:0], 4'hA};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Instance A: default 640x480 timing, RD_LAT=1, source stuck at white.
    logic        req_a, hs_a, vs_a, de_a, fs_a;
    logic [9:0]  x_a, y_a;
    logic [3:0]  r_a, g_a, b_a;
    logic [11:0] pix_a, rgb_a;
    assign pix_a = 12'hFFF;
    assign rgb_a = {r_a, g_a, b_a};

    vga_timing_gen u_a (
        .clk_vga(clk), .rst(rst), .en(en_a), .pix_req(req_a), .pix_x(x_a), .pix_y(y_a),
        .pix_data(pix_a), .red(r_a), .green(g_a), .blue(b_a), .hs(hs_a), .vs(vs_a),
        .de(de_a), .frame_start(fs_a));

    // Instance B: 8x4 frame, RD_LAT=0, source is combinational.
    logic        req_b, hs_b, vs_b, de_b, fs_b;
    logic [9:0]  x_b, y_b;
    logic [3:0]  r_b, g_b, b_b;
    logic [11:0] pix_b, rgb_b;
    assign pix_b = pat(x_b, y_b);
    assign rgb_b = {r_b, g_b, b_b};

    vga_timing_gen #(.H_SYNC(4), .H_BP(2), .H_ACT(8), .H_FP(2),
                     .V_SYNC(1), .V_BP(1), .V_ACT(4), .V_FP(1), .RD_LAT(0)) u_b (
        .clk_vga(clk), .rst(rst), .en(en_b), .pix_req(req_b), .pix_x(x_b), .pix_y(y_b),
        .pix_data(pix_b), .red(r_b), .green(g_b), .blue(b_b), .hs(hs_b), .vs(vs_b),
        .de(de_b), .frame_start(fs_b));

    // Instance C: 8x4 frame, RD_LAT=2, source answers two clocks after the request.
    logic        req_c, hs_c, vs_c, de_c, fs_c;
    logic [9:0]  x_c, y_c;
    logic [3:0]  r_c, g_c, b_c;
    logic [11:0] pix_c, rgb_c, src_d1;
    assign rgb_c = {r_c, g_c, b_c};

    always @(posedge clk) begin
        src_d1 <= pat(x_c, y_c);
        pix_c  <= src_d1;
    end

    vga_timing_gen #(.H_SYNC(4), .H_BP(2), .H_ACT(8), .H_FP(2),
                     .V_SYNC(1), .V_BP(1), .V_ACT(4), .V_FP(1), .RD_LAT(2)) u_c (
        .clk_vga(clk), .rst(rst), .en(en_c), .pix_req(req_c), .pix_x(x_c), .pix_y(y_c),
        .pix_data(pix_c), .red(r_c), .green(g_c), .blue(b_c), .hs(hs_c), .vs(vs_c),
        .de(de_c), .frame_start(fs_c));

    logic        de_m, fs_m;
    logic [11:0] rgb_m;
    assign de_m  = sel_c ? de_c  : de_b;
    assign fs_m  = sel_c ? fs_c  : fs_b;
    assign rgb_m = sel_c ? rgb_c : rgb_b;

    // Called on the frame_start sample; walks one 112-clock frame of the small config.
    task automatic capture_frame(input string nm);
        int   x, y, cnt;
        logic pde;
        check({nm, "_fs"}, 32'(fs_m), 32'd1);
        x = 0; y = 0; cnt = 0; pde = 1'b0;
        for (int i = 0; i < 112; i++) begin
            if (de_m) begin
                check({nm, "_pix"}, 32'(rgb_m), 32'(pat(10'(x), 10'(y))));
                x++;
                cnt++;
            end else begin
                check({nm, "_blank"}, 32'(rgb_m), 32'd0);
                if (pde) begin
                    check({nm, "_line_len"}, 32'(x), 32'd8);
                    y++;
                    x = 0;
                end
            end
            pde = de_m;
            @(negedge clk);
        end
        check({nm, "_de_cnt"}, 32'(cnt), 32'd32);
        check({nm, "_lines"}, 32'(y), 32'd4);
        check({nm, "_period"}, 32'(fs_m), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n, low, per, vsl, len, gap;
        logic [11:0] blank;

        rst = 1'b1; en_a = 1'b1; en_b = 1'b1; en_c = 1'b1; sel_c = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hs", 32'(hs_a), 32'd1);
        check("rst_vs", 32'(vs_a), 32'd1);
        check("rst_de", 32'(de_a), 32'd0);
        check("rst_rgb", 32'(rgb_a), 32'd0);
        check("rst_fs", 32'(fs_a), 32'd0);
        check("rst_req", 32'(req_a), 32'd0);

        rst = 1'b0;
        n = 0;
        while (hs_a && n < 20) begin @(negedge clk); n++; end
        check("a_rst_to_hs", 32'(n), 32'd2);
        check("a_vs_with_hs", 32'(vs_a), 32'd0);

        low = 1;
        forever begin @(negedge clk); if (hs_a || low > 2000) break; low++; end
        check("a_hs_low", 32'(low), 32'd96);
        per = low;
        forever begin @(negedge clk); per++; if (!hs_a || per > 2000) break; end
        check("a_hs_period", 32'(per), 32'd800);
        check("a_vs_line1", 32'(vs_a), 32'd0);
        vsl = per;
        forever begin @(negedge clk); vsl++; if (vs_a || vsl > 4000) break; end
        check("a_vs_low", 32'(vsl), 32'd1600);

        n = 0; blank = '0;
        while (!de_a && n < 30000) begin
            @(negedge clk); n++;
            if (!de_a) blank |= rgb_a;
        end
        check("a_first_de", 32'(n), 32'd26544);
        check("a_blank_rgb", 32'(blank), 32'd0);
        check("a_fs_first", 32'(fs_a), 32'd1);

        for (int l = 0; l < 2; l++) begin
            len = 0;
            while (de_a && len < 1000) begin
                check("a_rgb_act", 32'(rgb_a), 32'hFFF);
                len++;
                @(negedge clk);
            end
            check("a_de_len", 32'(len), 32'd640);
            gap = 0; blank = '0;
            while (!de_a && gap < 1000) begin blank |= rgb_a; gap++; @(negedge clk); end
            check("a_de_gap", 32'(gap), 32'd160);
            check("a_gap_rgb", 32'(blank), 32'd0);
            check("a_fs_later_line", 32'(fs_a), 32'd0);
        end

        repeat (100) @(negedge clk);
        check("a_pre_rst_de", 32'(de_a), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_hs", 32'(hs_a), 32'd1);
        check("midrst_vs", 32'(vs_a), 32'd1);
        check("midrst_de", 32'(de_a), 32'd0);
        check("midrst_rgb", 32'(rgb_a), 32'd0);
        check("midrst_fs", 32'(fs_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        n = 0;
        while (!fs_b && n < 400) begin @(negedge clk); n++; end
        check("b_fs_latency", 32'(n), 32'd39);
        capture_frame("b");

        en_b = 1'b0;
        #1;
        check("b_req_off", 32'(req_b), 32'd0);
        @(negedge clk);
        check("b_idle_hs", 32'(hs_b), 32'd1);
        check("b_idle_vs", 32'(vs_b), 32'd1);
        check("b_idle_de", 32'(de_b), 32'd0);
        check("b_idle_rgb", 32'(rgb_b), 32'd0);
        repeat (50) @(negedge clk);
        check("b_hold_de", 32'(de_b), 32'd0);
        check("b_hold_hs", 32'(hs_b), 32'd1);
        check("b_hold_req", 32'(req_b), 32'd0);

        en_b = 1'b1;
        n = 0;
        while (hs_b && n < 20) begin @(negedge clk); n++; end
        check("b_en_to_hs", 32'(n), 32'd1);
        check("b_en_vs", 32'(vs_b), 32'd0);
        while (!fs_b && n < 400) begin @(negedge clk); n++; end
        check("b_en_fs_latency", 32'(n), 32'd39);
        capture_frame("b2");

        sel_c = 1'b1;
        n = 0;
        while (!fs_c && n < 400) begin @(negedge clk); n++; end
        capture_frame("c");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
